// File: rtl/load_store_unit.sv
// RV32I load/store initiator for the data_memory port: one request at a time,
// effective-address generation, alignment/range/funct3 checks, load extension.
module load_store_unit #(
   parameter int MEM_BYTES = 2048,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_base,
   input  logic [31:0]       req_offset,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_misaligned,
   output logic              resp_fault,
   output logic              mem_re,
   output logic              mem_we,
   output logic [1:0]        mem_store_type,
   output logic [2:0]        mem_read_type,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_d_in,
   input  logic [31:0]       mem_d_out
);

   // state   | meaning
   // IDLE    | ready for a request; latches it on accept
   // DECODE  | checks latched request; faults go straight to RESP
   // ISSUE   | single-cycle mem_re or mem_we strobe
   // CAPTURE | memory read data is valid; slice and extend it
   // RESP    | response held until resp_ready
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_RESP
   } state_t;

   state_t      state;
   logic        lat_store;
   logic [2:0]  lat_f3;
   logic [31:0] lat_eff;
   logic [31:0] lat_wdata;

   logic        illegal;
   logic        misaligned;
   logic        out_of_range;
   logic [32:0] size_bytes;
   logic [1:0]  store_code;
   logic [2:0]  read_code;
   logic [31:0] wdata_masked;
   logic [31:0] load_ext;

   assign req_ready = (state == ST_IDLE);

   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      size_bytes = 33'd4;
      if (lat_store)
         illegal = lat_f3[2] | (lat_f3[1:0] == 2'b11);
      else
         illegal = (lat_f3[1:0] == 2'b11) | (lat_f3 == 3'b110);
      case (lat_f3[1:0])
         2'b00: size_bytes = 33'd1;
         2'b01: begin
            size_bytes = 33'd2;
            misaligned = lat_eff[0];
         end
         2'b10: begin
            size_bytes = 33'd4;
            misaligned = |lat_eff[1:0];
         end
         default: size_bytes = 33'd4;
      endcase
      // 33-bit compare so an address near 2^32 cannot wrap into range
      out_of_range = ({1'b0, lat_eff} + size_bytes) > 33'(MEM_BYTES);
   end

   always_comb begin
      store_code   = lat_f3[1:0] + 2'd1;
      read_code    = {1'b0, lat_f3[1:0] + 2'd1};
      wdata_masked = lat_wdata;
      case (lat_f3[1:0])
         2'b00:   wdata_masked = {24'd0, lat_wdata[7:0]};
         2'b01:   wdata_masked = {16'd0, lat_wdata[15:0]};
         default: wdata_masked = lat_wdata;
      endcase
   end

   // Upper bytes of mem_d_out may be stale for sub-word reads, so only the
   // accessed slice is used.
   always_comb begin
      load_ext = mem_d_out;
      case (lat_f3)
         3'b000:  load_ext = {{24{mem_d_out[7]}}, mem_d_out[7:0]};
         3'b001:  load_ext = {{16{mem_d_out[15]}}, mem_d_out[15:0]};
         3'b100:  load_ext = {24'd0, mem_d_out[7:0]};
         3'b101:  load_ext = {16'd0, mem_d_out[15:0]};
         default: load_ext = mem_d_out;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         lat_store       <= 1'b0;
         lat_f3          <= 3'd0;
         lat_eff         <= 32'd0;
         lat_wdata       <= 32'd0;
         resp_valid      <= 1'b0;
         resp_rdata      <= 32'd0;
         resp_misaligned <= 1'b0;
         resp_fault      <= 1'b0;
         mem_re          <= 1'b0;
         mem_we          <= 1'b0;
         mem_store_type  <= 2'b00;
         mem_read_type   <= 3'b000;
         mem_addr        <= '0;
         mem_d_in        <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_store <= req_is_store;
                  lat_f3    <= req_funct3;
                  lat_eff   <= req_base + req_offset;
                  lat_wdata <= req_wdata;
                  state     <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (illegal) begin
                  resp_valid <= 1'b1;
                  resp_fault <= 1'b1;
                  resp_rdata <= 32'd0;
                  state      <= ST_RESP;
               end else if (misaligned) begin
                  resp_valid      <= 1'b1;
                  resp_misaligned <= 1'b1;
                  resp_rdata      <= 32'd0;
                  state           <= ST_RESP;
               end else if (out_of_range) begin
                  resp_valid <= 1'b1;
                  resp_fault <= 1'b1;
                  resp_rdata <= 32'd0;
                  state      <= ST_RESP;
               end else begin
                  mem_re         <= ~lat_store;
                  mem_we         <= lat_store;
                  mem_addr       <= lat_eff[ADDR_W-1:0];
                  mem_store_type <= lat_store ? store_code : 2'b00;
                  mem_read_type  <= lat_store ? 3'b000 : read_code;
                  mem_d_in       <= lat_store ? wdata_masked : 32'd0;
                  state          <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mem_re         <= 1'b0;
               mem_we         <= 1'b0;
               mem_store_type <= 2'b00;
               mem_read_type  <= 3'b000;
               if (lat_store) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= 32'd0;
                  state      <= ST_RESP;
               end else begin
                  state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               resp_valid <= 1'b1;
               resp_rdata <= load_ext;
               state      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid      <= 1'b0;
                  resp_rdata      <= 32'd0;
                  resp_misaligned <= 1'b0;
                  resp_fault      <= 1'b0;
                  state           <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
